// File: rtl/braille_pkg.sv
// Shared types and constants for the Braille scroll controller.
// BRAILLE_DEBOUNCE_EN enables the key debounce stage.
package braille_pkg;

   localparam int CODE_W = 5;
   localparam logic [CODE_W-1:0] BLANK_CODE = 5'd0;
   localparam int DEPTH_DEF = 16;

`ifdef BRAILLE_DEBOUNCE_EN
   localparam bit DEB_EN = 1'b1;
`else
   localparam bit DEB_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      EDIT   = 2'd0,
      SCROLL = 2'd1,
      HOLD   = 2'd2
   } state_t;

   // pos+3 never exceeds 2P-1, so one subtract is enough
   function automatic logic [5:0] wrap6(input logic [5:0] i,
                                        input logic [5:0] p);
      return (i >= p) ? i - p : i;
   endfunction

endpackage

// File: rtl/braille_key_cond.sv
// Active-low key synchronizer, optional debounce, falling-edge pulse.
// Debounce stage is built only with BRAILLE_DEBOUNCE_EN.
module braille_key_cond
   import braille_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key,
   output logic press
);

   logic [1:0] s_q;
   logic       level;
   logic       prev_q;
   logic       press_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q <= 2'b11;
      end else begin
         s_q <= {s_q[0], key};
      end
   end

   if (DEB_EN && DEB_CYCLES > 0) begin : g_deb
      localparam int unsigned CW =
         (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
      logic [CW-1:0] cnt_q;
      logic          lvl_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q <= '0;
            lvl_q <= 1'b1;
         end else if (s_q[1]) begin
            cnt_q <= '0;
            lvl_q <= 1'b1;
         end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
            lvl_q <= 1'b0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end

      assign level = lvl_q;
   end else begin : g_raw
      assign level = s_q[1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q  <= 1'b1;
         press_q <= 1'b0;
      end else begin
         prev_q  <= level;
         press_q <= prev_q & ~level;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/braille_scroll_ctrl.sv
// Message buffer and EDIT/SCROLL/HOLD scheduler for the 4-slot display.
// Build with BRAILLE_DEBOUNCE_EN for debounced keys.
module braille_scroll_ctrl
   import braille_pkg::*;
#(
   parameter int DEPTH      = DEPTH_DEF,
   parameter int TICK_DIV   = 25000000,
   parameter int DEB_CYCLES = 1000000
) (
   input  logic              CLOCK_50,
   input  logic              RESET_N,
   input  logic [CODE_W-1:0] SW,
   input  logic              WR_KEY,
   input  logic              RUN_KEY,
   input  logic              CLR_KEY,
   output logic [CODE_W-1:0] CODE0,
   output logic [CODE_W-1:0] CODE1,
   output logic [CODE_W-1:0] CODE2,
   output logic [CODE_W-1:0] CODE3,
   output logic [4:0]        LEN,
   output logic              FULL,
   output logic [1:0]        STATE
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0] TERM = TW'(TICK_DIV - 1);

   logic wr_p;
   logic run_p;
   logic clr_p;

   state_t state_q, state_d;
   logic [4:0] len_q, len_d;
   logic [5:0] pos_q, pos_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic we;
   logic full;

   logic [CODE_W-1:0] mem_q [DEPTH];
   logic [CODE_W-1:0] code_q [4];
   logic [CODE_W-1:0] code_d [4];
   logic [5:0] win [4];
   logic [5:0] l6;
   logic [5:0] p6;

   braille_key_cond #(.DEB_CYCLES(DEB_CYCLES)) u_wr (
      .clk   (CLOCK_50),
      .rst_n (RESET_N),
      .key   (WR_KEY),
      .press (wr_p)
   );

   braille_key_cond #(.DEB_CYCLES(DEB_CYCLES)) u_run (
      .clk   (CLOCK_50),
      .rst_n (RESET_N),
      .key   (RUN_KEY),
      .press (run_p)
   );

   braille_key_cond #(.DEB_CYCLES(DEB_CYCLES)) u_clr (
      .clk   (CLOCK_50),
      .rst_n (RESET_N),
      .key   (CLR_KEY),
      .press (clr_p)
   );

   assign full = (len_q == 5'(DEPTH));
   assign l6   = {1'b0, len_q};
   assign p6   = l6 + 6'd4;

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      pos_d   = pos_q;
      cnt_d   = cnt_q;
      we      = 1'b0;
      if (clr_p) begin
         state_d = EDIT;
         len_d   = '0;
         pos_d   = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            EDIT: begin
               if (run_p) begin
                  if (len_q != '0) begin
                     state_d = SCROLL;
                     pos_d   = '0;
                     cnt_d   = '0;
                  end
               end else if (wr_p && !full) begin
                  we    = 1'b1;
                  len_d = len_q + 5'd1;
               end
            end
            SCROLL: begin
               if (run_p) begin
                  state_d = HOLD;
               end else if (cnt_q == TERM) begin
                  cnt_d = '0;
                  pos_d = (pos_q == p6 - 6'd1) ? '0 : pos_q + 6'd1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            HOLD: begin
               if (run_p) begin
                  state_d = SCROLL;
                  cnt_d   = '0;
               end
            end
            default: state_d = EDIT;
         endcase
      end
   end

   // Slot k of the scroll window; k=3 is the leftmost digit
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         win[k] = wrap6(pos_q + 6'(3 - k), p6);
      end
   end

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         code_d[k] = BLANK_CODE;
         if (state_q == EDIT) begin
            if (l6 > 6'(k)) begin
               code_d[k] = mem_q[IW'(l6 - 6'd1 - 6'(k))];
            end
         end else if (win[k] < l6) begin
            code_d[k] = mem_q[IW'(win[k])];
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (we) begin
         mem_q[IW'(len_q)] <= SW;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= EDIT;
         len_q   <= '0;
         pos_q   <= '0;
         cnt_q   <= '0;
         for (int k = 0; k < 4; k++) begin
            code_q[k] <= BLANK_CODE;
         end
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         pos_q   <= pos_d;
         cnt_q   <= cnt_d;
         for (int k = 0; k < 4; k++) begin
            code_q[k] <= code_d[k];
         end
      end
   end

   assign CODE0 = code_q[0];
   assign CODE1 = code_q[1];
   assign CODE2 = code_q[2];
   assign CODE3 = code_q[3];
   assign LEN   = len_q;
   assign FULL  = full;
   assign STATE = state_q;

endmodule

// File: tb/tb_braille_scroll_ctrl.sv
// Randomized bench for braille_scroll_ctrl against a queue-based model.
// Build with BRAILLE_DEBOUNCE_EN to exercise the debounce glitch case.
module tb_braille_scroll_ctrl;

   localparam int TICK = 4;
   localparam int DEB  = 8;
`ifdef BRAILLE_DEBOUNCE_EN
   localparam int PL = DEB + 3;
`else
   localparam int PL = 3;
`endif
   localparam int HUGE = 1 << 30;

   logic       CLOCK_50 = 1'b0;
   logic       RESET_N;
   logic [4:0] SW;
   logic       WR_KEY;
   logic       RUN_KEY;
   logic       CLR_KEY;
   logic [4:0] CODE0, CODE1, CODE2, CODE3;
   logic [4:0] LEN;
   logic       FULL;
   logic [1:0] STATE;

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;
   int mdl[$];
   int S, B, Hd;

   braille_scroll_ctrl #(
      .DEPTH(16), .TICK_DIV(TICK), .DEB_CYCLES(DEB)
   ) dut (
      .CLOCK_50 (CLOCK_50),
      .RESET_N  (RESET_N),
      .SW       (SW),
      .WR_KEY   (WR_KEY),
      .RUN_KEY  (RUN_KEY),
      .CLR_KEY  (CLR_KEY),
      .CODE0    (CODE0),
      .CODE1    (CODE1),
      .CODE2    (CODE2),
      .CODE3    (CODE3),
      .LEN      (LEN),
      .FULL     (FULL),
      .STATE    (STATE)
   );

   always #5 CLOCK_50 = ~CLOCK_50;
   always @(posedge CLOCK_50) cyc <= cyc + 1;

   initial begin
      #600000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   wire [19:0] codes = {CODE3, CODE2, CODE1, CODE0};

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%0h exp=%0h at cyc %0d",
                  tag, got, exp, cyc);
      end
   endtask

   function automatic logic [19:0] exp_edit();
      logic [19:0] w = '0;
      int L = mdl.size();
      for (int k = 3; k >= 0; k--) begin
         int j = L - 1 - k;
         w = {w[14:0], (j >= 0) ? 5'(mdl[j]) : 5'd0};
      end
      return w;
   endfunction

   function automatic logic [19:0] exp_scroll(input int p);
      logic [19:0] w = '0;
      int L = mdl.size();
      int P = L + 4;
      for (int k = 0; k < 4; k++) begin
         int i = (p + k) % P;
         w = {w[14:0], (i < L) ? 5'(mdl[i]) : 5'd0};
      end
      return w;
   endfunction

   // Position held after clock edge x, from scroll start/hold edges
   function automatic int pos_at(input int x);
      int P = mdl.size() + 4;
      if (x < S) return B % P;
      if (x >= Hd) return (B + (Hd - 1 - S) / TICK) % P;
      return (B + (x - S) / TICK) % P;
   endfunction

   task automatic press(input bit w, input bit r, input bit c,
                        output int f);
      @(negedge CLOCK_50);
      WR_KEY  = !w;
      RUN_KEY = !r;
      CLR_KEY = !c;
      f = cyc;
      repeat (PL) @(negedge CLOCK_50);
      WR_KEY  = 1'b1;
      RUN_KEY = 1'b1;
      CLR_KEY = 1'b1;
   endtask

   task automatic settle();
      repeat (2) @(negedge CLOCK_50);
   endtask

   task automatic write(input int v);
      int f;
      SW = 5'(v);
      press(1'b1, 1'b0, 1'b0, f);
      if (mdl.size() < 16) mdl.push_back(v);
      settle();
      check("len", LEN, mdl.size());
      check("full", FULL, mdl.size() == 16);
      check("edit_win", codes, exp_edit());
   endtask

   task automatic start_scroll();
      int f;
      press(1'b0, 1'b1, 1'b0, f);
      S  = f + PL + 1;
      B  = 0;
      Hd = HUGE;
      settle();
      check("state_scroll", STATE, 2'd1);
   endtask

   task automatic scroll_run(input int n);
      repeat (n) begin
         check("scroll_win", codes, exp_scroll(pos_at(cyc - 1)));
         @(negedge CLOCK_50);
      end
   endtask

   initial begin
      int f, fr, n;
      SW = '0;
      WR_KEY = 1'b1;
      RUN_KEY = 1'b1;
      CLR_KEY = 1'b1;
      RESET_N = 1'b0;
      S = 0;
      B = 0;
      Hd = HUGE;
      repeat (3) @(negedge CLOCK_50);
      check("rst_code0", CODE0, 5'd0);
      check("rst_code1", CODE1, 5'd0);
      check("rst_code2", CODE2, 5'd0);
      check("rst_code3", CODE3, 5'd0);
      check("rst_len", LEN, 5'd0);
      check("rst_full", FULL, 1'b0);
      check("rst_state", STATE, 2'd0);
      RESET_N = 1'b1;
      repeat (2) @(negedge CLOCK_50);

      write(3);
      write(9);
      write(11);
      check("plan_edit", codes, {5'd0, 5'd3, 5'd9, 5'd11});

      start_scroll();
      check("plan_scroll0", codes, {5'd3, 5'd9, 5'd11, 5'd0});
      scroll_run(2 * 7 * TICK);

      repeat ($urandom_range(0, 7)) @(negedge CLOCK_50);
      press(1'b0, 1'b1, 1'b0, f);
      Hd = f + PL + 1;
      settle();
      check("state_hold", STATE, 2'd2);
      scroll_run(24);

      fr = pos_at(Hd);
      press(1'b0, 1'b1, 1'b0, f);
      B  = fr;
      S  = f + PL + 1;
      Hd = HUGE;
      settle();
      check("state_resume", STATE, 2'd1);
      scroll_run(3 * TICK + 1);

      press(1'b0, 1'b1, 1'b1, f);
      mdl.delete();
      settle();
      check("clr_state", STATE, 2'd0);
      check("clr_len", LEN, 5'd0);
      check("clr_codes", codes, 20'd0);
      press(1'b0, 1'b1, 1'b0, f);
      settle();
      check("run_empty", STATE, 2'd0);

      for (int i = 0; i < 17; i++) begin
         write($urandom_range(1, 31));
      end
      start_scroll();
      scroll_run(20 * TICK + 6);

      @(negedge CLOCK_50);
      #1 RESET_N = 1'b0;
      #1;
      check("arst_codes", codes, 20'd0);
      check("arst_len", LEN, 5'd0);
      check("arst_full", FULL, 1'b0);
      check("arst_state", STATE, 2'd0);
      mdl.delete();
      @(negedge CLOCK_50);
      RESET_N = 1'b1;
      repeat (2) @(negedge CLOCK_50);

`ifdef BRAILLE_DEBOUNCE_EN
      SW = 5'd7;
      WR_KEY = 1'b0;
      repeat (5) @(negedge CLOCK_50);
      WR_KEY = 1'b1;
      repeat (20) @(negedge CLOCK_50);
      check("glitch_len", LEN, 5'd0);
`endif

      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
         write($urandom_range(0, 31));
      end
      start_scroll();
      scroll_run(2 * (n + 4) * TICK);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
